// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx
//   Slave-mode I2S receiver for the keyword-spotting front end. It captures
//   the left-channel word and ignores the right channel. An optional
//   first-order pre-emphasis filter can be applied to each word. The result
//   is handed to cnn_kws_accel with a one-clk strobe.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   en                       receive enable; when low the block idles
//   preemph_en               select pre-emphasis (quasi-static, sampled per word)
//   i2s_sck/i2s_ws/i2s_sd    asynchronous I2S bit clock, word select, data
//   err_clr                  one-clk clear of err_short
//   audio_sample [SAMPLE_W]  signed sample, held until the next strobe
//   sample_valid             one-clk strobe qualifying audio_sample
//   start                    pulse with the first sample after leaving IDLE
//   err_short                sticky flag: left word ended before SAMPLE_W bits
module i2s_audio_rx #(
  parameter int SAMPLE_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                preemph_en,
  input  logic                i2s_sck,
  input  logic                i2s_ws,
  input  logic                i2s_sd,
  input  logic                err_clr,
  output logic [SAMPLE_W-1:0] audio_sample,
  output logic                sample_valid,
  output logic                start,
  output logic                err_short
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam int EXT_W = SAMPLE_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLE_W - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {3'b000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {3'b111, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WAIT_L, SHIFT, SKIP_R} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ws_prev_q, ws_prev_d;   // ws seen at the previous sck edge
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]    sr_q, sr_d;
  logic                   word_done_q, word_done_d;
  logic [SAMPLE_W-1:0]    raw_q, raw_d;
  logic [SAMPLE_W-1:0]    x_prev_q, x_prev_d;
  logic [SAMPLE_W-1:0]    audio_sample_q, audio_sample_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   start_q, start_d;
  logic                   first_pending_q, first_pending_d;
  logic                   err_q, err_d;

  logic sck_s, ws_s, sd_s;
  logic sck_rise, ws_fall, in_shift, word_end, word_abort;
  logic signed [EXT_W-1:0] x_ext, xp_ext, pe_sum;
  logic [SAMPLE_W-1:0] pe_y;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];

  // All bit actions happen in the single clk where the synchronized sck rises.
  assign sck_rise   = sck_s & ~sck_prev_q;
  assign ws_fall    = sck_rise & ~ws_s & ws_prev_q;
  assign in_shift   = en & (state_q == SHIFT) & sck_rise;
  assign word_end   = in_shift & ~ws_s & (cnt_q == LAST_CNT);
  assign word_abort = in_shift & ws_s;

  // Process 1: state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      sck_sync_q      <= '0;
      ws_sync_q       <= '0;
      sd_sync_q       <= '0;
      sck_prev_q      <= 1'b0;
      ws_prev_q       <= 1'b0;
      cnt_q           <= '0;
      sr_q            <= '0;
      word_done_q     <= 1'b0;
      raw_q           <= '0;
      x_prev_q        <= '0;
      audio_sample_q  <= '0;
      sample_valid_q  <= 1'b0;
      start_q         <= 1'b0;
      first_pending_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge value, so ordering inside this block cannot matter.
      state_q         <= state_d;
      sck_sync_q      <= sck_sync_d;
      ws_sync_q       <= ws_sync_d;
      sd_sync_q       <= sd_sync_d;
      sck_prev_q      <= sck_prev_d;
      ws_prev_q       <= ws_prev_d;
      cnt_q           <= cnt_d;
      sr_q            <= sr_d;
      word_done_q     <= word_done_d;
      raw_q           <= raw_d;
      x_prev_q        <= x_prev_d;
      audio_sample_q  <= audio_sample_d;
      sample_valid_q  <= sample_valid_d;
      start_q         <= start_d;
      first_pending_q <= first_pending_d;
      err_q           <= err_d;
    end
  end

  // Process 2: next-state logic. en low overrides everything.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:           state_d = WAIT_L;
        WAIT_L, SKIP_R: if (ws_fall) state_d = SHIFT;
        SHIFT:          if (word_end || word_abort) state_d = SKIP_R;
        default:        state_d = IDLE;
      endcase
    end
  end

  // Pre-emphasis: y = x - x_prev + (x_prev >>> 5), two guard bits, saturated.
  always_comb begin
    x_ext  = {{2{raw_q[SAMPLE_W-1]}}, raw_q};
    xp_ext = {{2{x_prev_q[SAMPLE_W-1]}}, x_prev_q};
    pe_sum = x_ext - xp_ext + (xp_ext >>> 5);
    if (pe_sum > SAT_MAX)      pe_y = SAT_MAX[SAMPLE_W-1:0];
    else if (pe_sum < SAT_MIN) pe_y = SAT_MIN[SAMPLE_W-1:0];
    else                       pe_y = pe_sum[SAMPLE_W-1:0];
  end

  // Process 3: outputs and datapath next values.
  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sck_sync_d[i] = (i == 0) ? i2s_sck : sck_sync_q[(i == 0) ? 0 : i-1];
      ws_sync_d[i]  = (i == 0) ? i2s_ws  : ws_sync_q[(i == 0) ? 0 : i-1];
      sd_sync_d[i]  = (i == 0) ? i2s_sd  : sd_sync_q[(i == 0) ? 0 : i-1];
    end
    sck_prev_d      = sck_s;
    ws_prev_d       = sck_rise ? ws_s : ws_prev_q;
    cnt_d           = cnt_q;
    sr_d            = sr_q;
    word_done_d     = word_end;
    raw_d           = raw_q;
    x_prev_d        = x_prev_q;
    audio_sample_d  = audio_sample_q;
    sample_valid_d  = word_done_q;
    start_d         = 1'b0;
    first_pending_d = first_pending_q;
    err_d           = word_abort | (err_q & ~err_clr);

    // Entering SHIFT: the ws-fall edge itself carries no captured bit.
    if (state_d == SHIFT && state_q != SHIFT) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (in_shift && !ws_s) begin
      cnt_d = cnt_q + CNT_W'(1);
      sr_d  = {sr_q[SAMPLE_W-2:0], sd_s};
    end
    if (word_end) raw_d = {sr_q[SAMPLE_W-2:0], sd_s};

    // Second pipeline stage: a completed word is emitted even if en dropped.
    if (word_done_q) begin
      audio_sample_d  = preemph_en ? pe_y : raw_q;
      start_d         = first_pending_q;
      first_pending_d = 1'b0;
    end
    if (state_q == IDLE && en) first_pending_d = 1'b1;

    if (state_q == IDLE)  x_prev_d = '0;
    else if (word_done_q) x_prev_d = raw_q;
  end

  assign audio_sample = audio_sample_q;
  assign sample_valid = sample_valid_q;
  assign start        = start_q;
  assign err_short    = err_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Testbench for i2s_audio_rx: directed scenarios plus randomized frames,
// checked against a frame-level reference model (word value, pre-emphasis
// arithmetic, start/err bookkeeping, strobe latency).
module tb_i2s_audio_rx;

  localparam int W    = 16;
  localparam int SYNC = 2;
  localparam int HALF = 6;   // clk periods per sck half-period

  logic clk = 1'b0;
  logic rst, en, preemph_en, i2s_sck, i2s_ws, i2s_sd, err_clr;
  logic [W-1:0] audio_sample;
  logic sample_valid, start, err_short;

  i2s_audio_rx #(.SAMPLE_W(W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .preemph_en   (preemph_en),
    .i2s_sck      (i2s_sck),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .err_clr      (err_clr),
    .audio_sample (audio_sample),
    .sample_valid (sample_valid),
    .start        (start),
    .err_short    (err_short)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] val;
    logic         st;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  int           xp_m       = 0;
  logic [W-1:0] hold_m     = '0;
  logic         start_pend = 1'b0;
  logic         err_m      = 1'b0;
  logic         short_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] preemph(input int x, input int xp);
    int y;
    y = x - xp + (xp >>> 5);
    if (y > (1 << (W-1)) - 1) y = (1 << (W-1)) - 1;
    if (y < -(1 << (W-1)))    y = -(1 << (W-1));
    return y[W-1:0];
  endfunction

  task automatic sck_low(input logic ws, input logic sd);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sck_high();
    i2s_sck = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sck_edge(input logic ws, input logic sd);
    sck_low(ws, sd);
    sck_high();
  endtask

  // Right slot of nr bits (ws=1), then left slot: one ws-fall edge followed
  // by nl data bits. The word is complete when nl >= W; fewer bits make the
  // next ws=1 edge flag a short word.
  task automatic send_frame(input logic [W-1:0] lw, input int nl,
                            input int nr, input logic [W-1:0] rw);
    int x;
    logic b;
    for (int i = 0; i < nr; i++) sck_edge(1'b1, rw[W-1-(i % W)]);
    if (short_pend) begin
      err_m      = 1'b1;
      short_pend = 1'b0;
    end
    check("err_short_frame", err_short, err_m);
    b = 1'($urandom_range(0, 1));
    sck_edge(1'b0, b);
    for (int i = 0; i < nl; i++) begin
      b = (i < W) ? lw[W-1-i] : 1'($urandom_range(0, 1));
      sck_low(1'b0, b);
      if (i == W-1 && en) begin
        x = $signed(lw);
        exp_q.push_back('{preemph_en ? preemph(x, xp_m) : lw, start_pend, cyc + SYNC + 2});
        start_pend = 1'b0;
        xp_m       = x;
      end
      sck_high();
    end
    if (nl < W) short_pend = 1'b1;
  endtask

  task automatic reenable();
    en         = 1'b0;
    short_pend = 1'b0;
    xp_m       = 0;
    repeat (8) @(negedge clk);
    en         = 1'b1;
    start_pend = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_m   = 1'b0;
    @(negedge clk);
    check("err_after_clr", err_short, 1'b0);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    exp_q.delete();
    hold_m     = '0;
    xp_m       = 0;
    err_m      = 1'b0;
    short_pend = 1'b0;
    #1;
    check("rst_audio", audio_sample, '0);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_err", err_short, 1'b0);
    repeat (3) @(negedge clk);
    rst        = 1'b0;
    start_pend = en;
  endtask

  // Monitor: every strobe must match the head of the expected queue, at the
  // predicted cycle; between strobes the output holds and start stays low.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {16'h0, audio_sample}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sample", audio_sample, e.val);
          check("start_with_sample", start, e.st);
          check("latency_cycle", cyc, e.cyc);
          hold_m = e.val;
        end
      end else begin
        check("hold", audio_sample, hold_m);
        check("start_idle", start, 1'b0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, nr;
    logic [W-1:0] lw, rw;

    rst = 1'b1; en = 1'b0; preemph_en = 1'b0; err_clr = 1'b0;
    i2s_sck = 1'b0; i2s_ws = 1'b1; i2s_sd = 1'b0;
    repeat (3) @(negedge clk);
    check("por_audio", audio_sample, '0);
    check("por_valid", sample_valid, 1'b0);
    check("por_err", err_short, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    start_pend = 1'b1;
    repeat (4) @(negedge clk);

    // Plain word with start pulse.
    send_frame(16'h1234, W, W, 16'hFFFF);
    check("plain_0x1234", audio_sample, 16'h1234);

    // Pre-emphasis basics from a cleared history.
    reenable();
    preemph_en = 1'b1;
    send_frame(16'h4000, W, 4, 16'h0);
    check("pe_first", audio_sample, 16'h4000);
    send_frame(16'h4000, W, 4, 16'h0);
    check("pe_second", audio_sample, 16'h0200);

    // Saturation in both directions.
    reenable();
    send_frame(16'h8000, W, 3, 16'h0);
    send_frame(16'h7FFF, W, 3, 16'h0);
    check("sat_pos", audio_sample, 16'h7FFF);
    reenable();
    send_frame(16'h7FFF, W, 3, 16'h0);
    send_frame(16'h8000, W, 3, 16'h0);
    check("sat_neg", audio_sample, 16'h8000);
    preemph_en = 1'b0;

    // Short word, recovery, then clear.
    send_frame(16'hBEEF, 10, 5, 16'h0);
    send_frame(16'hA5A5, W, 5, 16'h0);
    check("after_short_err", err_short, 1'b1);
    check("after_short_word", audio_sample, 16'hA5A5);
    pulse_err_clr();

    // en dropped after 8 bits.
    send_frame(16'hCAFE, 8, 5, 16'h0);
    reenable();
    send_frame(16'h0F0F, W, 5, 16'h0);
    check("after_en_drop", audio_sample, 16'h0F0F);

    // Reset mid-word with err_short set and a non-zero held sample.
    send_frame(16'h1111, 5, 4, 16'h0);
    send_frame(16'h2222, 7, 4, 16'h0);
    check("pre_rst_err", err_short, 1'b1);
    do_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) sck_edge(1'b0, 1'b1);
    send_frame(16'h1357, W, 4, 16'h0);
    check("after_rst_word", audio_sample, 16'h1357);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      preemph_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) reenable();
      if ($urandom_range(0, 4) == 0) pulse_err_clr();
      lw = W'($urandom);
      rw = W'($urandom);
      nl = ($urandom_range(0, 5) == 0) ? $urandom_range(1, W-1) : W + $urandom_range(0, 2);
      nr = $urandom_range(1, 8);
      send_frame(lw, nl, nr, rw);
    end
    send_frame(16'h5A5A, W, 3, 16'h0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_audio_rx.md
I2S_AUDIO_RX -- requirements
Module: i2s_audio_rx

Interface
REQ-001 Parameter SAMPLE_W, default 16, shall set the audio word width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, shall set the flop depth of each input synchronizer.
REQ-003 clk  input  1  shall be the single system clock (wb_clk_i domain).
REQ-004 rst  input  1  shall be the reset: asynchronous, active-high.
REQ-005 en  input  1  shall enable reception; when low the block idles.
REQ-006 preemph_en  input  1  shall select pre-emphasis; it is quasi-static and sampled per word.
REQ-007 i2s_sck, i2s_ws, i2s_sd  input  1 each  shall be the asynchronous I2S bit clock, word select and data (slave mode).
REQ-008 err_clr  input  1  shall clear err_short when high for one clk.
REQ-009 audio_sample  output  SAMPLE_W  shall carry the signed sample to cnn_kws_accel.
REQ-010 sample_valid  output  1  shall be a one-clk strobe qualifying audio_sample.
REQ-011 start  output  1  shall be a one-clk pulse to cnn_kws_accel marking the first sample after enable.
REQ-012 err_short  output  1  shall be a sticky short-word error flag.

Function
REQ-013 Each of sck, ws and sd shall pass through a SYNC_STAGES-flop synchronizer; clk shall be at least 8x the sck frequency.
REQ-014 A sck rising edge shall be detected from the synchronized sck (previous 0, current 1); all bit actions occur in that detect cycle.
REQ-015 The FSM shall have states IDLE, WAIT_L, SHIFT and SKIP_R.
REQ-016 IDLE: entered while en=0; on en=1 it shall go to WAIT_L the next clk.
REQ-017 WAIT_L: on a sck edge where ws=0 and the ws value at the previous sck edge was 1, it shall go to SHIFT with bit counter 0 and no bit captured.
REQ-018 SHIFT: each subsequent sck edge shall shift sd in MSB-first and increment the counter; on capturing bit SAMPLE_W the word shall complete and the FSM go to SKIP_R.
REQ-019 SHIFT: if ws=1 at a sck edge before SAMPLE_W bits are captured, the word shall be discarded, err_short set, and the FSM go to SKIP_R.
REQ-020 SKIP_R: right-channel bits shall be ignored; a ws 1->0 transition at a sck edge shall enter SHIFT exactly as in WAIT_L.
REQ-021 Left-word bits beyond SAMPLE_W (ws still 0) shall be ignored.
REQ-022 en=0 in any state shall force IDLE the next clk, discarding a partial word; a word already completed shall still be emitted.
REQ-023 Pre-emphasis with preemph_en=1: y = x - x_prev + (x_prev >>> 5), computed at SAMPLE_W+2 signed bits and saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
REQ-024 Pre-emphasis with preemph_en=0: y = x.
REQ-025 x_prev shall be updated with raw x on every completed word, and shall be zeroed on rst and on entry to IDLE.
REQ-026 sample_valid shall assert exactly 2 clk after the detect cycle of bit SAMPLE_W, for one clk; audio_sample shall hold y until the next strobe.
REQ-027 start shall pulse in the same clk as the first sample_valid after each IDLE exit.
REQ-028 err_short shall stay set until err_clr; if a set and an err_clr coincide, the set shall win.

Reset
REQ-029 On rst (asynchronous) the FSM shall enter IDLE; audio_sample=0, sample_valid=0, start=0 and err_short=0; x_prev, the shift register, the counter and the synchronizers shall clear.
REQ-030 rst asserted mid-word shall discard the word and emit no strobe after release.

Verification
REQ-031 en=1, preemph_en=0, left word 0x1234 and right word 0xFFFF -> one sample_valid with 0x1234, start coincident, 2 clk after the 16th-bit edge.
REQ-032 preemph_en=1, left words 0x4000 then 0x4000 -> outputs 0x4000 then 0x0200.
REQ-033 preemph_en=1, words 0x8000 then 0x7FFF -> second output saturates to 0x7FFF; words 0x7FFF then 0x8000 -> second output 0x8000.
REQ-034 ws rises after 10 left bits -> no sample_valid, err_short=1; next good word emitted; err_clr -> err_short=0.
REQ-035 en dropped after bit 8, then re-raised -> no strobe for the partial word; the next full word produces sample_valid together with a new start pulse.
REQ-036 rst pulsed mid-word during SHIFT -> all outputs 0 immediately; no strobe until a fresh ws 1->0 and a full 16 bits.
